// File: rtl/score_digit_server_if.sv
`default_nettype none
// ============================================================================
//  Module   : score_digit_if
//  Purpose  : Score load / display digit request bundle between the score
//             counter, the display driver and score_digit_server.
//  Revision : 1.0
// ============================================================================
interface score_digit_if #(
    parameter int SCORE_W = 27
);
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic               blank_lz;
    logic [2:0]         refresh_rate;
    logic               busy;
    logic               done;
    logic [4:0]         digit_holder;

    modport master (
        output score, score_valid, blank_lz, refresh_rate,
        input  busy, done, digit_holder
    );

    modport slave (
        input  score, score_valid, blank_lz, refresh_rate,
        output busy, done, digit_holder
    );
endinterface
`default_nettype wire

// File: rtl/score_digit_server.sv
`default_nettype none
// ============================================================================
//  Module   : score_digit_server
//  Purpose  : Binary score to BCD via iterative double-dabble, double-buffered,
//             serving one registered digit code per display index.
//  Revision : 1.0
// ============================================================================
module score_digit_server #(
    parameter int                 SCORE_W    = 27,
    parameter int                 NUM_DIGITS = 8,
    parameter logic [4:0]         BLANK_CODE = 5'h1F,
    parameter logic [SCORE_W-1:0] SAT_VALUE  = SCORE_W'(99999999)
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    score_digit_if.slave bus
);
    localparam int                 c_BCD_W = 4 * NUM_DIGITS;
    localparam int                 c_CNT_W = $clog2(SCORE_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SCORE_W - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CONVERT = 2'd1;
    localparam logic [1:0] c_COMMIT  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [SCORE_W-1:0] r_bin;
    logic [c_BCD_W-1:0] r_shadow;
    logic [c_BCD_W-1:0] r_disp;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pend;
    logic [SCORE_W-1:0] r_pend_val;
    logic [4:0]         r_digit;

    logic [SCORE_W-1:0]    w_sat;
    logic                  w_load;
    logic [SCORE_W-1:0]    w_load_val;
    logic [c_BCD_W-1:0]    w_adj;
    logic [3:0]            w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic [4:0]            w_digit_next;

    assign w_sat      = (bus.score > SAT_VALUE) ? SAT_VALUE : bus.score;
    // In COMMIT a fresh valid is newer than anything already pending.
    assign w_load     = bus.score_valid | r_pend;
    assign w_load_val = bus.score_valid ? w_sat : r_pend_val;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_adj[4*i +: 4]  = (r_shadow[4*i +: 4] >= 4'd5) ?
                                      r_shadow[4*i +: 4] + 4'd3 : r_shadow[4*i +: 4];
            assign w_nib[i]        = r_disp[4*i +: 4];
            assign w_upper_zero[i] = (r_disp[c_BCD_W-1:4*i] == '0);
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (bus.score_valid) w_next_state = c_CONVERT;
            c_CONVERT: if (r_cnt == c_LAST) w_next_state = c_COMMIT;
            c_COMMIT:  w_next_state = w_load ? c_CONVERT : c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_digit_next = {1'b0, w_nib[bus.refresh_rate]};
        if (bus.blank_lz && (bus.refresh_rate != 3'd0) && w_upper_zero[bus.refresh_rate])
            w_digit_next = BLANK_CODE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_shadow   <= '0;
            r_disp     <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_digit    <= 5'd0;
        end else begin
            r_digit <= w_digit_next;
            case (r_state)
                c_IDLE: begin
                    if (bus.score_valid) begin
                        r_bin    <= w_sat;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                    end
                end
                c_CONVERT: begin
                    {r_shadow, r_bin} <= {w_adj[c_BCD_W-2:0], r_bin, 1'b0};
                    r_cnt             <= r_cnt + 1'b1;
                    if (bus.score_valid) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= w_sat;
                    end
                end
                c_COMMIT: begin
                    r_disp <= r_shadow;
                    if (w_load) begin
                        r_bin    <= w_load_val;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                        r_pend   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (r_state != c_IDLE);
    assign bus.done         = (r_state == c_COMMIT);
    assign bus.digit_holder = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_score_digit_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_digit_server
//  Purpose  : Self-checking bench for score_digit_server: timeline model plus
//             directed vectors with literal expectations.
//  Revision : 1.0
// ============================================================================
module tb_score_digit_server;
    localparam int SCORE_W = 27;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    score_digit_if #(.SCORE_W(SCORE_W)) sd_if ();

    score_digit_server #(.SCORE_W(SCORE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    endtask

    function automatic int unsigned sat(input logic [SCORE_W-1:0] s);
        return (s > 27'd99999999) ? 32'd99999999 : 32'(s);
    endfunction

    // Decimal digit of a value by plain arithmetic, with leading-zero blanking.
    function automatic logic [4:0] exp_dig(input int unsigned v, input logic [2:0] idx,
                                           input logic blz);
        int unsigned p = 1;
        for (int i = 0; i < int'(idx); i++) p = p * 10;
        if (blz && idx != 3'd0 && v < p) return 5'd31;
        return 5'((v / p) % 10);
    endfunction

    // Timeline model: a conversion accepted at edge e ends (display updated) at e+SCORE_W+1.
    int unsigned m_disp = 0, m_val = 0, m_pend_val = 0;
    bit          m_inflight = 0, m_pend = 0;
    int          m_exit = 0, m_edge = 0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [4:0]  m_digit = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_disp = 0; m_val = 0; m_pend_val = 0;
            m_inflight = 0; m_pend = 0; m_exit = 0;
            m_busy = 1'b0; m_done = 1'b0; m_digit = 5'd0;
        end else begin
            m_edge++;
            m_digit = exp_dig(m_disp, sd_if.refresh_rate, sd_if.blank_lz);
            if (m_inflight && m_edge == m_exit) begin
                m_disp = m_val;
                if (sd_if.score_valid || m_pend) begin
                    m_val  = sd_if.score_valid ? sat(sd_if.score) : m_pend_val;
                    m_pend = 0;
                    m_exit = m_edge + SCORE_W + 1;
                end else begin
                    m_inflight = 0;
                end
            end else if (m_inflight) begin
                if (sd_if.score_valid) begin
                    m_pend     = 1;
                    m_pend_val = sat(sd_if.score);
                end
            end else if (sd_if.score_valid) begin
                m_inflight = 1;
                m_val      = sat(sd_if.score);
                m_exit     = m_edge + SCORE_W + 1;
            end
            m_busy = m_inflight;
            m_done = m_inflight && (m_edge == m_exit - 1);
        end
    end

    always @(negedge clk) begin
        check("busy_model",  int'(sd_if.busy),         int'(m_busy));
        check("done_model",  int'(sd_if.done),         int'(m_done));
        check("digit_model", int'(sd_if.digit_holder), int'(m_digit));
    end

    task automatic pulse(input int v, output int t);
        @(posedge clk); #1;
        sd_if.score       = SCORE_W'(v);
        sd_if.score_valid = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        sd_if.score_valid = 1'b0;
    endtask

    // Checks the cycle distance from the valid cycle to the done cycle.
    task automatic wait_done(input int t, input int exp_cycles);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #3;
            if (sd_if.done) begin
                seen = 1;
                check("done_latency", cyc - t + 1, exp_cycles);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic sweep(input int idx, input int exp);
        @(posedge clk); #1;
        sd_if.refresh_rate = 3'(idx);
        @(posedge clk); #3;
        check($sformatf("digit_idx%0d", idx), int'(sd_if.digit_holder), exp);
    endtask

    int t0, t1, t2;

    initial begin
        sd_if.score        = '0;
        sd_if.score_valid  = 1'b0;
        sd_if.blank_lz     = 1'b0;
        sd_if.refresh_rate = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        check("reset_busy", int'(sd_if.busy), 0);
        check("reset_done", int'(sd_if.done), 0);
        for (int i = 0; i < 8; i++) sweep(i, 0);

        sd_if.blank_lz = 1'b1;
        pulse(1234, t0);
        wait_done(t0, 28);
        sweep(0, 4); sweep(1, 3); sweep(2, 2); sweep(3, 1);
        for (int i = 4; i < 8; i++) sweep(i, 31);
        sd_if.blank_lz = 1'b0;
        for (int i = 4; i < 8; i++) sweep(i, 0);

        pulse(100000000, t0);
        wait_done(t0, 28);
        for (int i = 0; i < 8; i++) sweep(i, 9);

        sd_if.blank_lz = 1'b1;
        pulse(0, t0);
        wait_done(t0, 28);
        sweep(0, 0);
        for (int i = 1; i < 8; i++) sweep(i, 31);

        sd_if.blank_lz = 1'b0;
        pulse(555, t0);
        repeat (3) @(posedge clk);
        pulse(777, t1);
        repeat (3) @(posedge clk);
        pulse(888, t2);
        check("pend_spacing", t2 - t0, 10);
        wait_done(t0, 28);
        sweep(0, 5); sweep(1, 5); sweep(2, 5);
        wait_done(t0, 56);
        sweep(0, 8); sweep(1, 8); sweep(2, 8); sweep(3, 0);

        pulse(42, t0);
        wait_done(t0, 28);
        sweep(0, 2); sweep(1, 4);
        pulse(9999, t0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",  int'(sd_if.busy), 0);
        check("rst_done",  int'(sd_if.done), 0);
        check("rst_digit", int'(sd_if.digit_holder), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #3;
        check("post_rst_busy", int'(sd_if.busy), 0);
        for (int i = 0; i < 8; i += 3) sweep(i, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
